bram_heap_queue: RTL

//   Parametrised binary-heap priority queue, one dual-port BRAM per tree level (levels 1..D-1), root in a register.

---
 rtl/bram_heap_queue.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/bram_heap_queue.sv
// bram_heap_queue: binary-heap priority queue, root held in a register, one dual-port RAM per lower tree level.
// Ports:
//   CLK, RST            clock and asynchronous active-high reset
//   i_push/i_pop/i_data insert, remove top, or replace top (push and pop together), sampled only while o_ready
//   o_ready             idle and accepting commands; o_valid = o_ready && queue not empty
//   o_data              current top of the heap (0 when empty)
//   o_full/o_empty      occupancy flags; o_count holds the number of stored keys
module bram_heap_queue #(
    parameter int QUEUE_SIZE = 31,
    parameter int DATA_WIDTH = 16,
    parameter bit MAX_HEAP   = 1'b1
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               i_push,
    input  logic                               i_pop,
    input  logic [DATA_WIDTH-1:0]              i_data,
    output logic                               o_ready,
    output logic                               o_valid,
    output logic [DATA_WIDTH-1:0]              o_data,
    output logic                               o_full,
    output logic                               o_empty,
    output logic [$clog2(QUEUE_SIZE+1)-1:0]    o_count
);
    localparam int D   = $clog2(QUEUE_SIZE + 1);
    localparam int IXW = $clog2(D);

    typedef enum logic [2:0] {IDLE, INS_STEP, INS_CMP, POP_RD, POP_LD, SD_RD, SD_CMP, SD_FIN} state_t;

    state_t                state_q, state_d;
    logic [D-1:0]          count_q, count_d, cur_q, cur_d, tgt_q, tgt_d, path_q, path_d;
    logic [DATA_WIDTH-1:0] root_q, root_d, carry_q, carry_d;
    logic [IXW-1:0]        rlvl_q, rlvl_d, wlvl;
    logic                  ready_q, ready_d, valid_q, valid_d, full_q, full_d, empty_q, empty_d;
    logic                  we, re, use_b, kids_w;
    logic [D-1:0]          wa, wa1, ra1, cnt1;
    logic [DATA_WIDTH-1:0] wd, rd_a, rd_b, win;
    logic [D:0]            c1, c2, widx;
    logic [D-1:0][DATA_WIDTH-1:0] qa_all, qb_all;

    // Tree level of a node given its index plus one: position of the leading one.
    function automatic logic [IXW-1:0] lvl_of(input logic [D-1:0] n1);
        lvl_of = '0;
        for (int k = 0; k < D; k++) if (n1[k]) lvl_of = IXW'(k);
    endfunction

    function automatic logic beats(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
        return MAX_HEAP ? (a > b) : (a < b);
    endfunction

    assign c1     = {cur_q, 1'b1};
    assign c2     = c1 + (D+1)'(1);
    assign cnt1   = count_q + D'(1);
    assign wa1    = wa + D'(1);
    assign wlvl   = lvl_of(wa1);
    assign rd_a   = qa_all[rlvl_q];
    assign rd_b   = qb_all[rlvl_q];
    // Left child wins ties so equal keys never move.
    assign use_b  = (c2 < {1'b0, count_q}) && beats(rd_b, rd_a);
    assign win    = use_b ? rd_b : rd_a;
    assign widx   = use_b ? c2 : c1;
    assign kids_w = {widx, 1'b1} < {2'b0, count_q};

    // Level 0 is the root register, so a "read" of node 0 simply selects it.
    assign qa_all[0] = root_q;
    assign qb_all[0] = root_q;

    // Within level l a node sits at offset (index+1) mod 2^l. Children are read together:
    // the left child on port A, its right sibling (odd offset) on port B.
    for (genvar l = 1; l < D; l++) begin : g_lvl
        logic [DATA_WIDTH-1:0] mem [2**l];
        logic [DATA_WIDTH-1:0] qa, qb;
        always_ff @(posedge CLK) begin
            if (we && wlvl == IXW'(l)) mem[wa1[l-1:0]] <= wd;
            if (re && lvl_of(ra1) == IXW'(l)) begin
                qa <= mem[ra1[l-1:0]];
                qb <= mem[ra1[l-1:0] | (l)'(1)];
            end
        end
        assign qa_all[l] = qa;
        assign qb_all[l] = qb;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        cur_d   = cur_q;
        tgt_d   = tgt_q;
        path_d  = path_q;
        root_d  = root_q;
        carry_d = carry_q;
        we      = 1'b0;
        wa      = cur_q;
        wd      = carry_q;
        re      = 1'b0;
        ra1     = cur_q + D'(1);
        case (state_q)
            IDLE: begin
                if (i_push && (i_pop ? empty_q : !full_q)) begin
                    count_d = cnt1;
                    tgt_d   = count_q;
                    carry_d = i_data;
                    cur_d   = '0;
                    // Bits of target+1 below its leading one steer left/right from the root down.
                    path_d  = cnt1 << (D - int'(lvl_of(cnt1)));
                    state_d = INS_STEP;
                end else if (i_pop && !empty_q) begin
                    carry_d = i_data;
                    cur_d   = '0;
                    if (!i_push) begin
                        count_d = count_q - D'(1);
                        root_d  = (count_q == D'(1)) ? '0 : root_q;
                        state_d = (count_q == D'(1)) ? IDLE : POP_RD;
                    end else begin
                        state_d = (count_q > D'(1)) ? SD_RD : SD_FIN;
                    end
                end
            end
            INS_STEP: begin
                we      = (cur_q == tgt_q);
                re      = !we;
                state_d = we ? IDLE : INS_CMP;
            end
            INS_CMP: begin
                if (beats(carry_q, rd_a)) begin
                    we      = 1'b1;
                    carry_d = rd_a;
                end
                cur_d   = D'(c1 + {{D{1'b0}}, path_q[D-1]});
                path_d  = path_q << 1;
                state_d = INS_STEP;
            end
            POP_RD: begin
                re      = 1'b1;
                ra1     = cnt1;
                state_d = POP_LD;
            end
            POP_LD: begin
                carry_d = rd_a;
                cur_d   = '0;
                state_d = (count_q > D'(1)) ? SD_RD : SD_FIN;
            end
            SD_RD: begin
                re      = 1'b1;
                ra1     = D'(c2);
                state_d = SD_CMP;
            end
            SD_CMP: begin
                if (beats(win, carry_q)) begin
                    we      = 1'b1;
                    wd      = win;
                    cur_d   = D'(widx);
                    state_d = kids_w ? SD_RD : SD_FIN;
                end else begin
                    state_d = SD_FIN;
                end
            end
            SD_FIN: begin
                we      = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (we && wa == '0) root_d = wd;
        rlvl_d  = re ? lvl_of(ra1) : rlvl_q;
        ready_d = (state_d == IDLE);
        valid_d = ready_d && (count_d != '0);
        full_d  = (count_d == D'(QUEUE_SIZE));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            count_q <= '0;
            cur_q   <= '0;
            tgt_q   <= '0;
            path_q  <= '0;
            root_q  <= '0;
            carry_q <= '0;
            rlvl_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            path_q  <= path_d;
            root_q  <= root_d;
            carry_q <= carry_d;
            rlvl_q  <= rlvl_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_data  = root_q;
    assign o_full  = full_q;
    assign o_empty = empty_q;
    assign o_count = count_q;
endmodule
